// File: rtl/lx32_lsu_pkg.sv
// lx32_lsu_pkg: shared types for the LX32 load/store unit.
//   size_e  - request access size encoding (2'b11 is illegal, no enumerator)
//   state_e - LSU sequencing FSM states
package lx32_lsu_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10
   } size_e;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      MERGE,
      STORE,
      RESP
   } state_e;

endpackage

// File: rtl/lx32_lsu_align.sv
// lx32_lsu_align: combinational lane handling for the LSU.
//   lane        in  byte lane within the word (addr[1:0])
//   size        in  access size (size_e encoding)
//   is_unsigned in  1 = zero-extend loads, 0 = sign-extend
//   rdata       in  full memory word
//   wdata       in  right-aligned store data
//   ld_data     out extracted and extended load value
//   st_data     out rdata with the addressed lanes replaced by wdata
module lx32_lsu_align
   import lx32_lsu_pkg::*;
(
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [31:0] rdata,
   input  logic [31:0] wdata,
   output logic [31:0] ld_data,
   output logic [31:0] st_data
);

   logic [7:0]  sel_b;
   logic [15:0] sel_h;

   always_comb begin
      case (lane)
         2'd0:    sel_b = rdata[7:0];
         2'd1:    sel_b = rdata[15:8];
         2'd2:    sel_b = rdata[23:16];
         default: sel_b = rdata[31:24];
      endcase
      // halves are only legal at lane 0 or 2
      sel_h = lane[1] ? rdata[31:16] : rdata[15:0];

      case (size)
         SZ_B:    ld_data = {{24{~is_unsigned & sel_b[7]}}, sel_b};
         SZ_H:    ld_data = {{16{~is_unsigned & sel_h[15]}}, sel_h};
         default: ld_data = rdata;
      endcase

      st_data = rdata;
      case (size)
         SZ_B: begin
            case (lane)
               2'd0:    st_data[7:0]   = wdata[7:0];
               2'd1:    st_data[15:8]  = wdata[7:0];
               2'd2:    st_data[23:16] = wdata[7:0];
               default: st_data[31:24] = wdata[7:0];
            endcase
         end
         SZ_H: begin
            if (lane[1]) st_data[31:16] = wdata[15:0];
            else         st_data[15:0]  = wdata[15:0];
         end
         default: st_data = wdata;
      endcase
   end

endmodule

// File: rtl/lx32_lsu.sv
// lx32_lsu: single-outstanding load/store unit in front of a word memory.
//   clk, rst_n         clock, synchronous active-low reset
//   req_valid/ready    request handshake (ready only in IDLE)
//   req_we/size/unsigned/addr/wdata  request fields
//   rsp_valid/rdata/err              one-cycle completion
//   d_addr/d_wdata/d_we/d_rdata      word memory port (combinational read)
// Sub-word stores are read-modify-write: MERGE reads the word, STORE writes it.
module lx32_lsu
   import lx32_lsu_pkg::*;
#(
   parameter int MEM_WORDS = 1024
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] d_addr,
   output logic [31:0] d_wdata,
   output logic        d_we,
   input  logic [31:0] d_rdata
);

   localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS) << 2;

   state_e      state;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;   // store data, replaced by the merged word in MERGE
   logic [1:0]  size_q;
   logic        we_q;
   logic        uns_q;
   logic        req_err;
   logic [31:0] ld_data;
   logic [31:0] st_data;

   assign req_ready = (state == IDLE) && rst_n;
   assign d_addr    = {addr_q[31:2], 2'b00};
   assign d_wdata   = wdata_q;

   always_comb begin
      req_err = 1'b0;
      if (req_size == 2'b11)                          req_err = 1'b1;
      if (req_size == SZ_H && req_addr[0])            req_err = 1'b1;
      if (req_size == SZ_W && req_addr[1:0] != 2'b00) req_err = 1'b1;
      if (req_addr >= ADDR_LIMIT)                     req_err = 1'b1;
   end

   lx32_lsu_align u_align (
      .lane        (addr_q[1:0]),
      .size        (size_q),
      .is_unsigned (uns_q),
      .rdata       (d_rdata),
      .wdata       (wdata_q),
      .ld_data     (ld_data),
      .st_data     (st_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         size_q    <= '0;
         we_q      <= 1'b0;
         uns_q     <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         d_we      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  size_q  <= req_size;
                  we_q    <= req_we;
                  uns_q   <= req_unsigned;
                  if (req_err) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                     state     <= RESP;
                  end else if (!req_we) begin
                     state <= LOAD;
                  end else if (req_size == SZ_W) begin
                     d_we  <= 1'b1;
                     state <= STORE;
                  end else begin
                     state <= MERGE;
                  end
               end
            end
            LOAD: begin
               rsp_valid <= 1'b1;
               rsp_rdata <= we_q ? '0 : ld_data;
               state     <= RESP;
            end
            MERGE: begin
               wdata_q <= st_data;
               d_we    <= 1'b1;
               state   <= STORE;
            end
            STORE: begin
               d_we      <= 1'b0;
               rsp_valid <= 1'b1;
               rsp_rdata <= '0;
               state     <= RESP;
            end
            RESP: begin
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_rdata <= '0;
               state     <= IDLE;
            end
            default: begin
               d_we      <= 1'b0;
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
